packet_merge: RTL
=================

# packet_merge

Two-input, one-output AXI4-Stream packet merger: the join-side counterpart of the capture duplicator. Re-combines the forwarded stream and the captured-copy stream, or any two packet streams, into a single stream. Packet-atomic round-robin arbitration: a packet is never interleaved with another. Each input is buffered in a small per-port FIFO, and per-port packet counters are exported for the register block.

## Interface
Parameters:
- C_M_AXIS_DATA_WIDTH, 256, output tdata width
- C_S_AXIS_DATA_WIDTH, 256, input tdata width; must equal C_M_AXIS_DATA_WIDTH
- C_M_AXIS_TUSER_WIDTH, 128, output tuser width
- C_S_AXIS_TUSER_WIDTH, 128, input tuser width; must equal C_M_AXIS_TUSER_WIDTH
- IN_FIFO_DEPTH_BITS, 4, log2 of per-input FIFO depth (16 beats)

Ports:
- **Clock and reset:** one clock; reset is asynchronous and active-low.
  - axi_aclk  in  1  sole clock
  - axi_aresetn  in  1  asynchronous, active-low reset
- **Slave inputs**, n = 0,1:
  - s_axis_tdata_n  in  C_S_AXIS_DATA_WIDTH  data
  - s_axis_tstrb_n  in  C_S_AXIS_DATA_WIDTH/8  byte strobes
  - s_axis_tuser_n  in  C_S_AXIS_TUSER_WIDTH  sideband
  - s_axis_tvalid_n  in  1  beat valid
  - s_axis_tready_n  out  1  beat accepted
  - s_axis_tlast_n  in  1  end of packet
- **Master output:**
  - m_axis_tdata  out  C_M_AXIS_DATA_WIDTH  merged data
  - m_axis_tstrb  out  C_M_AXIS_DATA_WIDTH/8  merged strobes
  - m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH  merged sideband, passed unmodified
  - m_axis_tvalid  out  1  beat valid
  - m_axis_tready  in  1  downstream ready
  - m_axis_tlast  out  1  end of packet
- **Statistics:**
  - pkt_cnt_0  out  32  packets forwarded from input 0
  - pkt_cnt_1  out  32  packets forwarded from input 1

## Operation
- **Input acceptance**
  - s_axis_tready_n = !fifo_n_nearly_full.
  - nearly_full asserts when occupancy ≥ depth-1.
  - Write on s_axis_tvalid_n & s_axis_tready_n; the word is {tlast, tuser, tstrb, tdata}.
- **FSM states:** IDLE, SEND0, SEND1. A last_grant register (1 bit) records the port that sent most recently.
- **IDLE**
  - m_axis_tvalid = 0.
  - If both FIFOs are non-empty, go to SEND(!last_grant).
  - Else go to SEND for whichever FIFO is non-empty.
  - Else stay in IDLE.
- **SENDn**
  - Output fields are driven from the head of FIFO n; m_axis_tvalid = !fifo_n_empty.
  - On m_axis_tvalid & m_axis_tready: pop FIFO n.
  - If the popped beat has tlast: increment pkt_cnt_n, set last_grant = n, then pick the next state:
    - SEND(other) if the other FIFO is non-empty (the check samples empty before this cycle's pop);
    - else SENDn if FIFO n is non-empty after the pop;
    - else IDLE.
  - A grant is held until tlast is accepted. An empty FIFO mid-packet deasserts tvalid but never releases the grant.
- **Output data when not sending:** in IDLE, m_axis_tdata/tstrb/tuser/tlast are driven to 0.
- **Counters** are 32-bit and wrap from 0xFFFF_FFFF to 0.
- **Single-beat packets** (tlast on the first beat) are legal.

## Timing
- **Reset values** while axi_aresetn = 0, applied asynchronously:
  - state = IDLE, last_grant = 1, so port 0 wins the first tie;
  - FIFOs emptied; m_axis_tvalid = 0; all m_axis data fields 0;
  - s_axis_tready_n = 0 during reset, 1 from the first cycle after release;
  - pkt_cnt_n = 0.
- **Reset mid-packet:** the partial packet is discarded. No tlast is emitted for it.
- **Latency from IDLE:** a beat written at cycle t is FIFO head at t+1. IDLE grants at t+1, and the beat appears on m_axis at t+2.
- **Latency while granted:** a beat enters the output one cycle after its write.
- **Back-to-back packets:** a switch between packets takes zero bubble cycles when the next FIFO is already non-empty.
- **Stalls:** while m_axis_tready = 0, m_axis_tvalid and all data fields hold stable (AXI rule).
- **Simultaneous write and pop** on one FIFO is allowed in the same cycle; occupancy is unchanged.
- **Throughput:** one beat per cycle sustained.

## Structure
- A shared package or header holds the FSM state encodings and FIFO word-width arithmetic (DATA + TUSER + DATA/8 + 1).
- One sub-module, merge_in_fifo, instantiated twice: fall-through FIFO with async active-low reset, empty and nearly_full outputs.
- Arbiter FSM and counters live in the top module.

## Test plan
- **Single packet, port 0:** 3-beat packet on input 0 after reset.
  - Beats appear on m_axis at cycles t+2..t+4 with identical tdata/tstrb/tuser; tlast on beat 3.
  - pkt_cnt_0 = 1, pkt_cnt_1 = 0.
- **Tie after reset:** 4-beat packets loaded on both inputs in the same cycle.
  - All 4 port-0 beats are output, then 4 port-1 beats with no idle cycle between; never interleaved.
- **Backpressure:** m_axis_tready toggles 1,0,1,0 mid-packet.
  - Data held stable while tready = 0.
  - With tready = 0 and a continuous input burst, s_axis_tready_0 drops after 15 beats are buffered.
- **Sustained load:** 100 single-beat packets per port, tready = 1.
  - Output alternates strictly 0,1,0,1…
  - pkt_cnt_0 = pkt_cnt_1 = 100; 200 cycles of tvalid after the first grant.
- **Reset mid-packet:** axi_aresetn asserted after beat 2 of 5.
  - m_axis_tvalid = 0 in the same cycle; counters 0.
  - A fresh 2-beat packet after release is output intact with tlast.
- **Starved mid-packet:** input 0 pauses 5 cycles mid-packet while input 1 has a packet waiting.
  - tvalid = 0 for those cycles; the port-1 packet is output only after port 0's tlast.

Source files
------------

// File: rtl/packet_merge_pkg.sv
// packet_merge_pkg: shared definitions for the two-input packet merger.
//   state_t          arbiter FSM states
//   fifo_word_width  width of one buffered beat {tlast, tuser, tstrb, tdata}
package packet_merge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2
  } state_t;

  function automatic int unsigned fifo_word_width(input int unsigned data_w,
                                                  input int unsigned user_w);
    return data_w + user_w + data_w / 8 + 1;
  endfunction

endpackage

// File: rtl/packet_merge_in_fifo.sv
// merge_in_fifo: fall-through FIFO buffering one merger input.
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   din, wr_en   write port; writes are dropped while nearly_full
//   dout, rd_en  head word (valid whenever !empty), pop request
//   empty        no words held
//   nearly_full  occupancy >= depth-1, also held high during reset
//   more         at least two words held (still non-empty after one pop)
module merge_in_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             nearly_full,
  output logic             more
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] NF_LEVEL = (DEPTH_BITS + 1)'(DEPTH - 1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS:0]   count;
  logic                  running;
  logic                  do_wr;
  logic                  do_rd;

  assign empty       = (count == '0);
  // Blocking writes during reset keeps the upstream tready low until the
  // first edge after release.
  assign nearly_full = !running || (count >= NF_LEVEL);
  assign more        = (count[DEPTH_BITS:1] != '0);
  assign dout        = mem[rd_ptr];
  assign do_wr       = wr_en && !nearly_full;
  assign do_rd       = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      running <= 1'b0;
    end else begin
      running <= 1'b1;
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/packet_merge.sv
// packet_merge: two-input, one-output AXI4-Stream packet merger with
// packet-atomic round-robin arbitration.
//   axi_aclk, axi_aresetn          clock, asynchronous active-low reset
//   s_axis_*_0, s_axis_*_1         slave inputs, each buffered in a FIFO
//   m_axis_*                       merged master output (tuser unmodified)
//   pkt_cnt_0, pkt_cnt_1           wrapping counts of packets forwarded
module packet_merge
  import packet_merge_pkg::*;
#(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned IN_FIFO_DEPTH_BITS   = 4
) (
  input  logic                              axi_aclk,
  input  logic                              axi_aresetn,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_0,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_0,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_0,
  input  logic                              s_axis_tvalid_0,
  output logic                              s_axis_tready_0,
  input  logic                              s_axis_tlast_0,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_1,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_1,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_1,
  input  logic                              s_axis_tvalid_1,
  output logic                              s_axis_tready_1,
  input  logic                              s_axis_tlast_1,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,

  output logic [31:0]                       pkt_cnt_0,
  output logic [31:0]                       pkt_cnt_1
);

  localparam int unsigned FW = fifo_word_width(C_S_AXIS_DATA_WIDTH, C_S_AXIS_TUSER_WIDTH);

  logic [FW-1:0] head0, head1;
  logic          empty0, empty1;
  logic          nf0, nf1;
  logic          more0, more1;
  logic          pop0, pop1;
  logic          done0, done1;
  state_t        state, state_nx;
  logic          last_grant;

  assign s_axis_tready_0 = !nf0;
  assign s_axis_tready_1 = !nf1;

  merge_in_fifo #(.WIDTH(FW), .DEPTH_BITS(IN_FIFO_DEPTH_BITS)) u_fifo0 (
    .clk         (axi_aclk),
    .rst_n       (axi_aresetn),
    .din         ({s_axis_tlast_0, s_axis_tuser_0, s_axis_tstrb_0, s_axis_tdata_0}),
    .wr_en       (s_axis_tvalid_0 && s_axis_tready_0),
    .rd_en       (pop0),
    .dout        (head0),
    .empty       (empty0),
    .nearly_full (nf0),
    .more        (more0)
  );

  merge_in_fifo #(.WIDTH(FW), .DEPTH_BITS(IN_FIFO_DEPTH_BITS)) u_fifo1 (
    .clk         (axi_aclk),
    .rst_n       (axi_aresetn),
    .din         ({s_axis_tlast_1, s_axis_tuser_1, s_axis_tstrb_1, s_axis_tdata_1}),
    .wr_en       (s_axis_tvalid_1 && s_axis_tready_1),
    .rd_en       (pop1),
    .dout        (head1),
    .empty       (empty1),
    .nearly_full (nf1),
    .more        (more1)
  );

  // After the tlast pop: the other port is preferred if it was non-empty
  // before this cycle's pop; otherwise stay on the same port only if it
  // still holds a word after the pop.
  always_comb begin
    state_nx      = state;
    pop0          = 1'b0;
    pop1          = 1'b0;
    done0         = 1'b0;
    done1         = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tstrb  = '0;
    m_axis_tuser  = '0;
    m_axis_tlast  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty0 && !empty1) state_nx = last_grant ? SEND0 : SEND1;
        else if (!empty0)       state_nx = SEND0;
        else if (!empty1)       state_nx = SEND1;
      end
      SEND0: begin
        {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata} = head0;
        m_axis_tvalid = !empty0;
        if (!empty0 && m_axis_tready) begin
          pop0 = 1'b1;
          if (head0[FW-1]) begin
            done0    = 1'b1;
            state_nx = !empty1 ? SEND1 : (more0 ? SEND0 : IDLE);
          end
        end
      end
      SEND1: begin
        {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata} = head1;
        m_axis_tvalid = !empty1;
        if (!empty1 && m_axis_tready) begin
          pop1 = 1'b1;
          if (head1[FW-1]) begin
            done1    = 1'b1;
            state_nx = !empty0 ? SEND0 : (more1 ? SEND1 : IDLE);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      pkt_cnt_0  <= '0;
      pkt_cnt_1  <= '0;
    end else begin
      state <= state_nx;
      if (done0) begin
        last_grant <= 1'b0;
        pkt_cnt_0  <= pkt_cnt_0 + 32'd1;
      end
      if (done1) begin
        last_grant <= 1'b1;
        pkt_cnt_1  <= pkt_cnt_1 + 32'd1;
      end
    end
  end

endmodule
